// File: rtl/writeback_unit.sv
// Writeback unit: single-slot result buffer in front of the register file
// write port, load alignment and result selection, plus a per-register
// pending-write scoreboard that produces the decode stall.
module writeback_unit #(
  parameter int DATAW    = 32,
  parameter int ADDRW    = 5,
  parameter int NUM_REGS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [ADDRW-1:0] issue_rd,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [ADDRW-1:0] wb_rd,
  input  logic [1:0]       wb_sel,
  input  logic [2:0]       wb_funct3,
  input  logic [DATAW-1:0] wb_alu,
  input  logic [DATAW-1:0] wb_mem,
  input  logic [DATAW-1:0] wb_pc,
  input  logic             rf_hold,
  output logic             write_enable,
  output logic [ADDRW-1:0] addr_rd,
  output logic [DATAW-1:0] data_rd,
  input  logic [ADDRW-1:0] chk_rs1,
  input  logic [ADDRW-1:0] chk_rs2,
  output logic             stall,
  output logic             sb_overflow
);

  // Counter array covers the whole address space; entries 0 and
  // NUM_REGS..DEPTH-1 are tied to zero so any address can index it safely.
  localparam int DEPTH = 1 << ADDRW;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Extract the addressed byte/halfword and extend it; unknown load types
  // pass the raw memory word through.
  function automatic logic [DATAW-1:0] load_align(input logic [2:0]       funct3,
                                                  input logic [1:0]       lane,
                                                  input logic [DATAW-1:0] word);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [DATAW-1:0]   res;
    byte_s = word[{lane, 3'b000} +: 8];
    half_s = word[{lane[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   res = DATAW'(byte_s);
      F3_LH:   res = DATAW'(half_s);
      F3_LW:   res = word;
      F3_LBU:  res = DATAW'($unsigned(byte_s));
      F3_LHU:  res = DATAW'($unsigned(half_s));
      default: res = word;
    endcase
    return res;
  endfunction

  // Saturating 2-bit pending counter helpers.
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // A source blocks decode while its register has a pending write, unless
  // the last outstanding write is committing right now.
  function automatic logic src_blocked(input logic [ADDRW-1:0] rs,
                                       input logic [1:0]       cnt,
                                       input logic             commit_now,
                                       input logic [ADDRW-1:0] commit_rd);
    logic last_commit;
    last_commit = (cnt == 2'd1) && commit_now && (commit_rd == rs);
    return (rs != '0) && (cnt != 2'd0) && !last_commit;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [ADDRW-1:0] addr_rd_q, addr_rd_d;
  logic [DATAW-1:0] data_rd_q, data_rd_d;
  logic             sb_overflow_q, sb_overflow_d;
  logic [1:0]       cnt_q [DEPTH];
  logic [1:0]       cnt_d [DEPTH];

  logic             drain;
  logic             commit;
  logic             xfer;
  logic [DATAW-1:0] wb_result;

  // The slot empties whenever the register file is free; writes to x0 are
  // drained without a commit.
  assign drain        = out_valid_q && !rf_hold;
  assign commit       = drain && (addr_rd_q != '0);
  assign wb_ready     = !out_valid_q || !rf_hold;
  assign xfer         = wb_valid && wb_ready;
  assign write_enable = commit;
  assign addr_rd      = addr_rd_q;
  assign data_rd      = data_rd_q;
  assign sb_overflow  = sb_overflow_q;
  assign stall        = src_blocked(chk_rs1, cnt_q[chk_rs1], commit, addr_rd_q) ||
                        src_blocked(chk_rs2, cnt_q[chk_rs2], commit, addr_rd_q);

  // Select the value to be written back for the presented result.
  always_comb begin
    wb_result = '0;
    case (wb_sel)
      SEL_ALU:  wb_result = wb_alu;
      SEL_LOAD: wb_result = load_align(wb_funct3, wb_alu[1:0], wb_mem);
      SEL_PC4:  wb_result = wb_pc + DATAW'(4);
      default:  wb_result = '0;
    endcase
  end

  // Output slot: reload on transfer, clear after drain, hold under rf_hold.
  always_comb begin
    out_valid_d = out_valid_q;
    addr_rd_d   = addr_rd_q;
    data_rd_d   = data_rd_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      addr_rd_d   = wb_rd;
      data_rd_d   = wb_result;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // Scoreboard: issue increments, commit decrements, both together cancel.
  always_comb begin
    sb_overflow_d = sb_overflow_q;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i == 0 || i >= NUM_REGS) begin
        cnt_d[i] = 2'd0;
      end else if ((issue_valid && issue_rd == ADDRW'(i)) &&
                   !(commit && addr_rd_q == ADDRW'(i))) begin
        cnt_d[i] = sat_inc(cnt_q[i]);
        if (cnt_q[i] == 2'd3) sb_overflow_d = 1'b1;
      end else if (!(issue_valid && issue_rd == ADDRW'(i)) &&
                   (commit && addr_rd_q == ADDRW'(i))) begin
        cnt_d[i] = sat_dec(cnt_q[i]);
      end
    end
  end

  // State registers; reset discards the slot and clears the scoreboard.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      addr_rd_q     <= '0;
      data_rd_q     <= '0;
      sb_overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= 2'd0;
    end else begin
      out_valid_q   <= out_valid_d;
      addr_rd_q     <= addr_rd_d;
      data_rd_q     <= data_rd_d;
      sb_overflow_q <= sb_overflow_d;
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: directed vectors with literal expectations
// plus a cycle-by-cycle comparison against a behavioural model.
module tb_writeback_unit;

  localparam int DATAW    = 32;
  localparam int ADDRW    = 5;
  localparam int NUM_REGS = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              issue_valid;
  logic [ADDRW-1:0]  issue_rd;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDRW-1:0]  wb_rd;
  logic [1:0]        wb_sel;
  logic [2:0]        wb_funct3;
  logic [DATAW-1:0]  wb_alu, wb_mem, wb_pc;
  logic              rf_hold;
  logic              write_enable;
  logic [ADDRW-1:0]  addr_rd;
  logic [DATAW-1:0]  data_rd;
  logic [ADDRW-1:0]  chk_rs1, chk_rs2;
  logic              stall;
  logic              sb_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_unit #(.DATAW(DATAW), .ADDRW(ADDRW), .NUM_REGS(NUM_REGS)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_sel(wb_sel), .wb_funct3(wb_funct3),
    .wb_alu(wb_alu), .wb_mem(wb_mem), .wb_pc(wb_pc),
    .rf_hold(rf_hold),
    .write_enable(write_enable), .addr_rd(addr_rd), .data_rd(data_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .stall(stall), .sb_overflow(sb_overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Written-back value from the select/load rules, with plain arithmetic.
  function automatic logic [31:0] model_value(input logic [1:0] sel, input logic [2:0] f3,
                                              input logic [31:0] alu, input logic [31:0] mem,
                                              input logic [31:0] pc);
    logic [31:0] b, h, r;
    b = (mem >> (int'(alu[1:0]) * 8)) & 32'hFF;
    h = (mem >> (int'(alu[1]) * 16)) & 32'hFFFF;
    case (sel)
      2'd0: r = alu;
      2'd2: r = pc + 32'd4;
      2'd3: r = 32'd0;
      default: begin
        case (f3)
          3'd0:    r = (b >= 32'd128)   ? b - 32'd256   : b;
          3'd1:    r = (h >= 32'd32768) ? h - 32'd65536 : h;
          3'd4:    r = b;
          3'd5:    r = h;
          default: r = mem;
        endcase
      end
    endcase
    return r;
  endfunction

  // Behavioural model state
  logic        m_valid;
  int          m_rd;
  logic [31:0] m_data;
  int          m_cnt [NUM_REGS];
  logic        m_ovf;

  function automatic logic model_stall(input int rs, input logic cm);
    if (rs == 0) return 1'b0;
    if (m_cnt[rs] == 0) return 1'b0;
    if (m_cnt[rs] == 1 && cm && m_rd == rs) return 1'b0;
    return 1'b1;
  endfunction

  // Compare DUT against the model mid-cycle, then advance the model.
  always @(negedge clock) begin : cmp
    logic ready_e, commit_e, stall_e;
    int   inc_rd, dec_rd;
    if (reset) begin
      check("rst_ready", 32'(wb_ready), 32'd1);
      check("rst_we",    32'(write_enable), 32'd0);
      check("rst_addr",  32'(addr_rd), 32'd0);
      check("rst_data",  data_rd, 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_ovf",   32'(sb_overflow), 32'd0);
      m_valid = 1'b0; m_rd = 0; m_data = '0; m_ovf = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) m_cnt[i] = 0;
    end else begin
      ready_e  = !m_valid || !rf_hold;
      commit_e = m_valid && !rf_hold && m_rd != 0;
      stall_e  = model_stall(int'(chk_rs1), commit_e) || model_stall(int'(chk_rs2), commit_e);
      check("m_ready", 32'(wb_ready), 32'(ready_e));
      check("m_we",    32'(write_enable), 32'(commit_e));
      check("m_stall", 32'(stall), 32'(stall_e));
      check("m_ovf",   32'(sb_overflow), 32'(m_ovf));
      if (m_valid) begin
        check("m_addr", 32'(addr_rd), 32'(m_rd));
        check("m_data", data_rd, m_data);
      end
      inc_rd = (issue_valid && issue_rd != 0) ? int'(issue_rd) : -1;
      dec_rd = commit_e ? m_rd : -1;
      if (!(inc_rd >= 0 && inc_rd == dec_rd)) begin
        if (inc_rd >= 0) begin
          if (m_cnt[inc_rd] == 3) m_ovf = 1'b1;
          else m_cnt[inc_rd] = m_cnt[inc_rd] + 1;
        end
        if (dec_rd >= 0 && m_cnt[dec_rd] > 0) m_cnt[dec_rd] = m_cnt[dec_rd] - 1;
      end
      if (wb_valid && ready_e) begin
        m_valid = 1'b1;
        m_rd    = int'(wb_rd);
        m_data  = model_value(wb_sel, wb_funct3, wb_alu, wb_mem, wb_pc);
      end else if (m_valid && !rf_hold) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
    wb_valid = 1'b1; wb_rd = rd; wb_sel = sel; wb_funct3 = f3;
    wb_alu = alu; wb_mem = mem; wb_pc = pc;
  endtask

  // Present one result to rd 5 and check the commit one cycle later.
  task automatic run_vec(input string name, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc, input logic [31:0] exp);
    set_wb(5'd5, sel, f3, alu, mem, pc);
    cyc();
    wb_valid = 1'b0;
    @(negedge clock);
    check({name, "_we"},   32'(write_enable), 32'd1);
    check({name, "_addr"}, 32'(addr_rd), 32'd5);
    check({name, "_data"}, data_rd, exp);
    cyc();
  endtask

  initial begin
    reset = 1'b0; issue_valid = 1'b0; issue_rd = '0; wb_valid = 1'b0; wb_rd = '0;
    wb_sel = '0; wb_funct3 = '0; wb_alu = '0; wb_mem = '0; wb_pc = '0; rf_hold = 1'b0;
    chk_rs1 = '0; chk_rs2 = '0;
    #2 reset = 1'b1;
    @(negedge clock);
    check("reset_ready", 32'(wb_ready), 32'd1);
    check("reset_we",    32'(write_enable), 32'd0);
    check("reset_data",  data_rd, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    // Result selection and load alignment
    run_vec("lb",      2'd1, 3'd0, 32'h1003, 32'h80FF_1234, 32'h0, 32'hFFFF_FF80);
    run_vec("lhu",     2'd1, 3'd5, 32'h1003, 32'h80FF_1234, 32'h0, 32'h0000_80FF);
    run_vec("pc_wrap", 2'd2, 3'd0, 32'h0,    32'h0,         32'hFFFF_FFFC, 32'h0);
    run_vec("pc4",     2'd2, 3'd0, 32'h0,    32'h0,         32'h0000_0100, 32'h0000_0104);
    run_vec("alu",     2'd0, 3'd0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'h1234_5678);
    run_vec("rsvd",    2'd3, 3'd0, 32'h1234, 32'h5678, 32'h9ABC, 32'h0);
    run_vec("lh_lo",   2'd1, 3'd1, 32'h1000, 32'h80FF_1234, 32'h0, 32'h0000_1234);
    run_vec("lh_hi",   2'd1, 3'd1, 32'h1002, 32'h80FF_1234, 32'h0, 32'hFFFF_80FF);
    run_vec("lb_b2",   2'd1, 3'd0, 32'h1002, 32'h80FF_1234, 32'h0, 32'hFFFF_FFFF);
    run_vec("lbu_b1",  2'd1, 3'd4, 32'h1001, 32'h80FF_1234, 32'h0, 32'h0000_0012);
    run_vec("lbu_b3",  2'd1, 3'd4, 32'h1003, 32'h80FF_1234, 32'h0, 32'h0000_0080);
    run_vec("lw",      2'd1, 3'd2, 32'h1002, 32'h80FF_1234, 32'h0, 32'h80FF_1234);
    run_vec("f3_3",    2'd1, 3'd3, 32'h1001, 32'h80FF_1234, 32'h0, 32'h80FF_1234);
    run_vec("f3_6",    2'd1, 3'd6, 32'h1003, 32'h80FF_1234, 32'h0, 32'h80FF_1234);

    // Result to x0: accepted, never written
    set_wb(5'd0, 2'd0, 3'd0, 32'hDEAD, 32'h0, 32'h0);
    cyc();
    wb_valid = 1'b0;
    @(negedge clock);
    check("x0_we", 32'(write_enable), 32'd0);
    cyc();

    // Back-pressure from the register file
    set_wb(5'd6, 2'd0, 3'd0, 32'hAA, 32'h0, 32'h0);
    cyc();
    wb_valid = 1'b0;
    rf_hold  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("hold_ready", 32'(wb_ready), 32'd0);
      check("hold_we",    32'(write_enable), 32'd0);
      check("hold_data",  data_rd, 32'hAA);
      cyc();
      if (k == 1) set_wb(5'd8, 2'd0, 3'd0, 32'hBB, 32'h0, 32'h0);
    end
    rf_hold = 1'b0;
    @(negedge clock);
    check("rel_we",    32'(write_enable), 32'd1);
    check("rel_addr",  32'(addr_rd), 32'd6);
    check("rel_ready", 32'(wb_ready), 32'd1);
    cyc();
    wb_valid = 1'b0;
    @(negedge clock);
    check("queued_addr", 32'(addr_rd), 32'd8);
    check("queued_data", data_rd, 32'hBB);
    cyc();
    @(negedge clock);
    check("single_commit_we", 32'(write_enable), 32'd0);
    cyc();

    // Scoreboard: issue, stall, commit release
    issue_valid = 1'b1; issue_rd = 5'd7;
    cyc();
    issue_valid = 1'b0; chk_rs1 = 5'd7;
    @(negedge clock);
    check("sb_stall_pending", 32'(stall), 32'd1);
    cyc();
    set_wb(5'd7, 2'd0, 3'd0, 32'h7, 32'h0, 32'h0);
    cyc();
    wb_valid = 1'b0;
    @(negedge clock);
    check("sb_commit_we", 32'(write_enable), 32'd1);
    check("sb_stall_commit_cycle", 32'(stall), 32'd0);
    cyc();
    @(negedge clock);
    check("sb_stall_cleared", 32'(stall), 32'd0);
    cyc();
    // Issue and commit to the same register together leave the count at 1
    issue_valid = 1'b1; issue_rd = 5'd7;
    cyc();
    issue_valid = 1'b0;
    set_wb(5'd7, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0);
    cyc();
    wb_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd7;
    @(negedge clock);
    check("sb_same_we", 32'(write_enable), 32'd1);
    cyc();
    issue_valid = 1'b0;
    @(negedge clock);
    check("sb_same_unchanged", 32'(stall), 32'd1);
    cyc();
    chk_rs1 = 5'd0; chk_rs2 = 5'd7;
    @(negedge clock);
    check("sb_rs2_stall", 32'(stall), 32'd1);
    cyc();
    set_wb(5'd7, 2'd0, 3'd0, 32'h1, 32'h0, 32'h0);
    cyc();
    wb_valid = 1'b0;
    cyc();
    @(negedge clock);
    check("sb_rs2_released", 32'(stall), 32'd0);
    cyc();
    chk_rs2 = 5'd0;

    // Counter saturation and sticky overflow
    issue_valid = 1'b1; issue_rd = 5'd9;
    cyc(); cyc(); cyc();
    @(negedge clock);
    check("ovf_before", 32'(sb_overflow), 32'd0);
    cyc();
    issue_rd = 5'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd9;
    @(negedge clock);
    check("ovf_set", 32'(sb_overflow), 32'd1);
    check("ovf_rs2_stall", 32'(stall), 32'd1);
    cyc();
    issue_valid = 1'b1; issue_rd = 5'd0; chk_rs2 = 5'd0;
    @(negedge clock);
    check("x0_issue_stall", 32'(stall), 32'd0);
    check("ovf_sticky", 32'(sb_overflow), 32'd1);
    cyc();
    issue_valid = 1'b0;

    // Asynchronous reset with a full slot and pending counters
    set_wb(5'd10, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0);
    cyc();
    wb_valid = 1'b0; rf_hold = 1'b1; chk_rs2 = 5'd9;
    #2 reset = 1'b1;
    #1;
    check("arst_we",    32'(write_enable), 32'd0);
    check("arst_addr",  32'(addr_rd), 32'd0);
    check("arst_data",  data_rd, 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_ovf",   32'(sb_overflow), 32'd0);
    check("arst_ready", 32'(wb_ready), 32'd1);
    rf_hold = 1'b0;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_we",    32'(write_enable), 32'd0);
    check("post_rst_stall", 32'(stall), 32'd0);
    cyc();
    chk_rs2 = 5'd0;

    // Mixed traffic checked only by the model
    for (int n = 0; n < 80; n++) begin
      wb_valid    = 1'($urandom_range(0, 1));
      wb_rd       = 5'($urandom_range(0, 15));
      wb_sel      = 2'($urandom_range(0, 3));
      wb_funct3   = 3'($urandom_range(0, 7));
      wb_alu      = $urandom;
      wb_mem      = $urandom;
      wb_pc       = $urandom;
      rf_hold     = ($urandom_range(0, 3) == 0);
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 15));
      chk_rs1     = 5'($urandom_range(0, 15));
      chk_rs2     = 5'($urandom_range(0, 15));
      cyc();
    end
    wb_valid = 1'b0; rf_hold = 1'b0; issue_valid = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
